// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if
//   Groups the host handshake, the read-data return path and the SPI pins
//   of the SPI master controller into one bundle.
//
//   Signals:
//     start, frame[9:0]     host request and 10-bit command frame
//     ready, busy, done     controller status and frame-completion pulse
//     rd_data[7:0],rd_valid byte returned by a read-data frame
//     SS_n, MOSI, MISO      SPI pins towards the slave wrapper
//     cmd_err               only when SPI_MASTER_CMD_ORDER_EN is defined
//
//   Modports:
//     master  the controller side (spi_master_ctrl)
//     slave   the host / pin side that talks to the controller
interface spi_master_ctrl_if;
    logic       start;
    logic [9:0] frame;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
`ifdef SPI_MASTER_CMD_ORDER_EN
    logic       cmd_err;

    modport master (
        input  start, frame, MISO,
        output ready, busy, done, rd_data, rd_valid, SS_n, MOSI, cmd_err
    );

    modport slave (
        output start, frame, MISO,
        input  ready, busy, done, rd_data, rd_valid, SS_n, MOSI, cmd_err
    );
`else
    modport master (
        input  start, frame, MISO,
        output ready, busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, frame, MISO,
        input  ready, busy, done, rd_data, rd_valid, SS_n, MOSI
    );
`endif
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Host-side SPI master for the SPI slave + single-port RAM wrapper. The
//   system clock is also the bit clock. A 10-bit command frame is sent
//   MSB-first under SS_n (one command-check cycle repeating frame[9], then
//   ten data bits). Read-data frames (cmd 2'b11) then idle READ_LATENCY
//   cycles and shift 8 bits in from MISO, MSB first, into rd_data.
//
//   Parameters:
//     READ_LATENCY  dummy cycles between last MOSI bit and first MISO sample
//     GAP_CYCLES    cycles SS_n stays high after each frame (>= 1)
//
//   Ports:
//     clk    system / SPI bit clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    spi_master_ctrl_if.master (handshake, read return, SPI pins)
//
//   Optional feature (macro SPI_MASTER_CMD_ORDER_EN):
//     Rejects a wr-data start not directly after a wr-addr frame, and a
//     rd-data start not directly after a rd-addr frame, pulsing cmd_err.
module spi_master_ctrl #(
    parameter int READ_LATENCY = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_ctrl_if.master   bus
);

    typedef enum logic [2:0] {IDLE, CHK, SHIFT, WAIT, RECV, GAP} state_t;

    // One down-counter serves every timed state, so it must hold the
    // largest of the bit index (9), the read latency and the gap length.
    localparam int MAX_A   = (READ_LATENCY > GAP_CYCLES) ? READ_LATENCY : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_A > 9) ? MAX_A : 9;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_FIRST = CNT_W'(9);
    localparam logic [CNT_W-1:0] RX_FIRST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       f;
    logic [6:0]       shreg;
    logic [7:0]       rd_data_q;
    logic             is_read;
    logic             start_ok;

    assign is_read = (f[9:8] == 2'b11);

`ifdef SPI_MASTER_CMD_ORDER_EN
    logic       last_vld;
    logic [1:0] last_cmd;
    logic       reject;
    logic       cmd_err_q;

    // A data command is only legal right after its matching address command.
    assign reject = ((bus.frame[9:8] == 2'b11) && !(last_vld && last_cmd == 2'b10)) ||
                    ((bus.frame[9:8] == 2'b01) && !(last_vld && last_cmd == 2'b00));
    assign start_ok = bus.start && !reject;

    // Remember the last accepted command; flag a rejected start for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld  <= 1'b0;
            last_cmd  <= 2'b00;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= (state == IDLE) && bus.start && reject;
            if (state == IDLE && start_ok) begin
                last_vld <= 1'b1;
                last_cmd <= bus.frame[9:8];
            end
        end
    end

    assign bus.cmd_err = cmd_err_q;
`else
    assign start_ok = bus.start;
`endif

    // State register plus the datapath it sequences: frame shadow, the
    // shared down-counter, the MISO shift register and the returned byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            f         <= '0;
            shreg     <= '0;
            rd_data_q <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_ok) f <= bus.frame;
                end
                CHK:   cnt <= BIT_FIRST;
                SHIFT: begin
                    if (cnt == '0) begin
                        if (!is_read)              cnt <= GAP_LAST;
                        else if (READ_LATENCY > 0) cnt <= WAIT_LAST;
                        else                       cnt <= RX_FIRST;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                WAIT: cnt <= (cnt == '0) ? RX_FIRST : cnt - ONE;
                RECV: begin
                    shreg <= {shreg[5:0], bus.MISO};
                    if (cnt == '0) begin
                        rd_data_q <= {shreg, bus.MISO};
                        cnt       <= GAP_LAST;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                GAP:     cnt <= (cnt == '0) ? '0 : cnt - ONE;
                default: cnt <= '0;
            endcase
        end
    end

    // Next-state selection; every timed state leaves when the counter hits 0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start_ok) next_state = CHK;
            CHK:   next_state = SHIFT;
            SHIFT: if (cnt == '0) begin
                       if (!is_read)              next_state = GAP;
                       else if (READ_LATENCY > 0) next_state = WAIT;
                       else                       next_state = RECV;
                   end
            WAIT:  if (cnt == '0) next_state = RECV;
            RECV:  if (cnt == '0) next_state = GAP;
            GAP:   if (cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state only, so a reset forces SS_n high at once.
    // done marks the first gap cycle, where the counter still holds GAP_LAST.
    always_comb begin
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.ready    = (state == IDLE);
        bus.busy     = (state != IDLE);
        bus.done     = (state == GAP) && (cnt == GAP_LAST);
        bus.rd_valid = (state == GAP) && (cnt == GAP_LAST) && is_read;
        bus.rd_data  = rd_data_q;
        case (state)
            CHK: begin
                bus.SS_n = 1'b0;
                bus.MOSI = f[9];
            end
            SHIFT: begin
                bus.SS_n = 1'b0;
                bus.MOSI = f[cnt[3:0]];
            end
            WAIT, RECV: bus.SS_n = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl. Every accepted frame is expanded
//   into a list of per-cycle expectations (SS_n, MOSI, done, rd_valid,
//   rd_data and the MISO bit the slave returns) from the frame layout:
//   one check cycle, ten data bits, optional latency and eight receive
//   cycles, then the gap. A tiny slave-RAM model supplies read bytes.
module tb_spi_master_ctrl;

    localparam int READ_LATENCY = 2;
    localparam int GAP_CYCLES   = 1;

    typedef struct {
        logic       ss;
        logic       mosi;
        logic       done;
        logic       rv;
        logic [7:0] rdd;
        logic       miso;
    } cyc_t;

    logic clk;
    logic rst_n;

    spi_master_ctrl_if host ();

    spi_master_ctrl #(
        .READ_LATENCY (READ_LATENCY),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (host)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    cyc_t q[$];
    logic [7:0] model_rd = 8'h00;
    logic [7:0] m_mem [256];
    logic [7:0] m_waddr = 8'h00;
    logic [7:0] m_raddr = 8'h00;
    logic       m_last_vld = 1'b0;
    logic [1:0] m_last_cmd = 2'b00;
    logic       pending_err = 1'b0;

    int          ss_low   = 0;
    int          done_cnt = 0;
    int          rv_cnt   = 0;
    int          err_cnt  = 0;
    logic [31:0] mosi_cap = 32'h0;

    function automatic cyc_t mk(input logic ss, input logic mosi, input logic done,
                                input logic rv, input logic [7:0] rdd, input logic miso);
        cyc_t c;
        c.ss = ss; c.mosi = mosi; c.done = done; c.rv = rv; c.rdd = rdd; c.miso = miso;
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand an accepted (or rejected) frame into expected cycles.
    task automatic modelAccept(input logic [9:0] fr);
        logic       rd;
        logic [7:0] b;
        mosi_cap = 32'h0; ss_low = 0; done_cnt = 0; rv_cnt = 0; err_cnt = 0;
`ifdef SPI_MASTER_CMD_ORDER_EN
        if ((fr[9:8] == 2'b11 && !(m_last_vld && m_last_cmd == 2'b10)) ||
            (fr[9:8] == 2'b01 && !(m_last_vld && m_last_cmd == 2'b00))) begin
            pending_err = 1'b1;
            return;
        end
        m_last_vld = 1'b1;
        m_last_cmd = fr[9:8];
`endif
        rd = (fr[9:8] == 2'b11);
        b  = 8'h00;
        case (fr[9:8])
            2'b00: m_waddr = fr[7:0];
            2'b01: m_mem[m_waddr] = fr[7:0];
            2'b10: m_raddr = fr[7:0];
            default: b = m_mem[m_raddr];
        endcase
        q.push_back(mk(1'b0, fr[9], 1'b0, 1'b0, model_rd, 1'b1));
        for (int i = 9; i >= 0; i--) q.push_back(mk(1'b0, fr[i], 1'b0, 1'b0, model_rd, 1'b1));
        if (rd) begin
            for (int i = 0; i < READ_LATENCY; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, model_rd, 1'b1));
            for (int i = 7; i >= 0; i--) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, model_rd, b[i]));
            model_rd = b;
        end
        for (int g = 0; g < GAP_CYCLES; g++)
            q.push_back(mk(1'b1, 1'b0, g == 0, rd && g == 0, model_rd, 1'b0));
    endtask

    // Present a frame for one clock edge while the controller is idle.
    task automatic applyStimulus(input logic [9:0] fr);
        @(negedge clk);
        host.start = 1'b1;
        host.frame = fr;
        @(posedge clk);
        #1;
        modelAccept(fr);
        host.start = 1'b0;
        host.frame = 10'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout: %0d cycles still expected, required 0", q.size());
            q.delete();
        end
    endtask

    // Per-cycle comparison against the expected-cycle list; also drives MISO.
    cyc_t cur;
    logic exp_busy;
    logic exp_err;
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
                exp_busy = 1'b1;
            end else begin
                cur = mk(1'b1, 1'b0, 1'b0, 1'b0, model_rd, 1'b0);
                exp_busy = 1'b0;
            end
            host.MISO = cur.miso;
            checkOutput("SS_n", 32'(host.SS_n), 32'(cur.ss));
            checkOutput("MOSI", 32'(host.MOSI), 32'(cur.mosi));
            checkOutput("done", 32'(host.done), 32'(cur.done));
            checkOutput("rd_valid", 32'(host.rd_valid), 32'(cur.rv));
            checkOutput("rd_data", 32'(host.rd_data), 32'(cur.rdd));
            checkOutput("busy", 32'(host.busy), 32'(exp_busy));
            checkOutput("ready", 32'(host.ready), 32'(!exp_busy));
`ifdef SPI_MASTER_CMD_ORDER_EN
            exp_err = pending_err;
            pending_err = 1'b0;
            checkOutput("cmd_err", 32'(host.cmd_err), 32'(exp_err));
            if (host.cmd_err) err_cnt++;
`endif
            if (!host.SS_n) begin
                ss_low++;
                mosi_cap = {mosi_cap[30:0], host.MOSI};
            end
            if (host.done) done_cnt++;
            if (host.rd_valid) rv_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        rst_n      = 1'b0;
        host.start = 1'b0;
        host.frame = 10'h000;

        // Reset values while held in reset.
        #12;
        checkOutput("rst_SS_n", 32'(host.SS_n), 32'h1);
        checkOutput("rst_MOSI", 32'(host.MOSI), 32'h0);
        checkOutput("rst_ready", 32'(host.ready), 32'h1);
        checkOutput("rst_busy", 32'(host.busy), 32'h0);
        checkOutput("rst_done", 32'(host.done), 32'h0);
        checkOutput("rst_rd_data", 32'(host.rd_data), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("idle_SS_n", 32'(host.SS_n), 32'h1);
        checkOutput("idle_ready", 32'(host.ready), 32'h1);

        // Single wr-addr frame.
        $display("[TB] wr-addr 0x12");
        applyStimulus(10'h012);
        waitIdle();
        checkOutput("t1_mosi_seq", mosi_cap, 32'h0000_0012);
        checkOutput("t1_ss_low", 32'(ss_low), 32'd11);
        checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("t1_rv_cnt", 32'(rv_cnt), 32'd0);

        // wr-addr then wr-data, with a start raised on the done cycle.
        $display("[TB] wr-addr 0x12 / wr-data 0xA5");
        applyStimulus(10'h012);
        waitIdle();
        applyStimulus(10'h1A5);
        repeat (12) @(negedge clk);
        host.start = 1'b1;
        host.frame = 10'h2FF;
        @(posedge clk);
        #1 host.start = 1'b0;
        waitIdle();
        checkOutput("t2_mosi_seq", mosi_cap, 32'h0000_01A5);
        checkOutput("t2_ss_low", 32'(ss_low), 32'd11);
        checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge clk);

        // rd-addr 0x12 then rd-data returns 0xA5.
        $display("[TB] rd-addr 0x12 / rd-data");
        applyStimulus(10'h212);
        waitIdle();
        applyStimulus(10'h300);
        waitIdle();
        checkOutput("t3_ss_low", 32'(ss_low), 32'd21);
        checkOutput("t3_mosi_seq", mosi_cap, 32'h001C_0000);
        checkOutput("t3_rd_data", 32'(host.rd_data), 32'h0000_00A5);
        checkOutput("t3_rv_cnt", 32'(rv_cnt), 32'd1);
        checkOutput("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Second data pattern through address 0x3C.
        $display("[TB] write/read 0x5A at 0x3C");
        applyStimulus(10'h03C); waitIdle();
        applyStimulus(10'h15A); waitIdle();
        applyStimulus(10'h23C); waitIdle();
        applyStimulus(10'h300); waitIdle();
        checkOutput("t4_rd_data", 32'(host.rd_data), 32'h0000_005A);

        // Reset during SHIFT cycle 4 of a wr-data frame.
        $display("[TB] reset mid-frame");
        applyStimulus(10'h012); waitIdle();
        applyStimulus(10'h1C3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        model_rd   = 8'h00;
        m_last_vld = 1'b0;
        #1;
        checkOutput("t5_SS_n_async", 32'(host.SS_n), 32'h1);
        checkOutput("t5_busy_async", 32'(host.busy), 32'h0);
        checkOutput("t5_rd_data_clr", 32'(host.rd_data), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t5_ready", 32'(host.ready), 32'h1);
        checkOutput("t5_done_cnt", 32'(done_cnt), 32'd0);

        // rd-data directly after reset.
        $display("[TB] rd-data right after reset");
        applyStimulus(10'h300);
        waitIdle();
        repeat (3) @(negedge clk);
        #1;
`ifdef SPI_MASTER_CMD_ORDER_EN
        checkOutput("t6_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("t6_ss_low", 32'(ss_low), 32'd0);
        checkOutput("t6_ready", 32'(host.ready), 32'h1);
`else
        checkOutput("t6_ss_low", 32'(ss_low), 32'd21);
        checkOutput("t6_rd_data", 32'(host.rd_data), 32'h0000_005A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
